demux32_writer: RTL
===================

Name: demux32_writer

Overview:
- Write-side counterpart of the 32:1 by-32 read multiplexer: a 1-to-32 demultiplexer that steers accepted data words into one of 32 registered lanes.
- Lanes are exported flattened and feed the 32-input read mux directly, forming the write half of the register bank.
- Supports single addressed writes and auto-incrementing bursts with wrap-around, behind a valid/ready handshake.

Parameters:
- WIDTH, 32, data width of each lane.
- ZERO_REG, 1, when 1, lane 0 is hardwired to zero; writes to address 0 are accepted and discarded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all lanes and lane_valid; aborts any burst.
- in_valid  input  1  data word offered.
- in_ready  output  1  block accepts the word this cycle.
- in_addr  input  5  target lane for single writes; ignored during a burst.
- in_data  input  WIDTH  data word.
- burst_start  input  1  pulse that begins a burst; sampled only in IDLE.
- burst_base  input  5  first lane of the burst.
- burst_len  input  6  number of words, 1..32; 0 means the burst is ignored.
- busy  output  1  high while in BURST.
- done  output  1  one-cycle pulse after the last burst word is written.
- we_onehot  output  32  registered one-hot of the lane written last cycle; all zero otherwise.
- lanes  output  32*WIDTH  flattened lane registers; lane k occupies bits [k*WIDTH +: WIDTH].
- lane_valid  output  32  bit k is set once lane k has been written since reset or clear.

Behaviour:
- Reset (reset_n=0, asynchronous): all lanes 0, lane_valid 0, we_onehot 0, done 0, state IDLE, burst pointer 0, remaining count 0.
- Accept condition: accept = in_valid & in_ready.
- States: IDLE and BURST.
- IDLE:
  - in_ready = ~clear & ~burst_start.
  - An accepted word writes lane in_addr.
  - burst_start with burst_len != 0: next state BURST, pointer = burst_base, remaining = burst_len.
  - burst_start with burst_len = 0: no effect; in_ready is still low that cycle.
- BURST:
  - in_ready = ~clear; busy = 1; burst_start is ignored.
  - Each accepted word writes lane at the pointer; pointer = (pointer+1) mod 32, so 31 wraps to 0; remaining decrements.
  - When remaining goes 1->0 on an accept: next state IDLE and done = 1 on the following cycle.
- Write latency:
  - A word accepted at edge N is visible on lanes at N+1.
  - we_onehot has a single bit set at N+1, for exactly one cycle.
  - lane_valid bit sets at N+1.
- ZERO_REG=1 and target lane 0:
  - Handshake completes and the burst pointer and count advance.
  - Lane 0 stays 0, we_onehot stays 0, lane_valid[0] stays 0.
- A burst of 32 starting at base b overwrites all lanes exactly once, ending at lane (b+31) mod 32.
- clear has priority over all writes:
  - Lanes and lane_valid are zeroed; state goes to IDLE, with no done pulse.
  - in_ready is 0 during clear, so no word is lost silently.
- Back-to-back accepts every cycle are supported; throughput is 1 word/cycle.
- in_valid deasserting mid-burst stalls the burst; the pointer and count hold.
- Reset asserted mid-burst returns everything immediately to reset values.
- No output depends combinationally on in_data or in_addr; in_ready depends only on clear, burst_start and state.

Decomposition:
- Shared package: LANES=32, ADDR_W=5, LEN_W=6, state encoding (IDLE, BURST).
- One natural sub-module, decoder5to32: a combinational 5-bit to one-hot decoder with an enable. It is shared with the write-enable logic of the register file.

Test Plan:
- Single write: in_addr=5, in_data=0xDEADBEEF, one accept -> next cycle lane 5 = 0xDEADBEEF, we_onehot=0x00000020, lane_valid[5]=1; all other lanes 0.
- Burst wrap: base=30, len=4, words 0xA0..0xA3 on consecutive cycles -> lanes 30,31,0,1 written in order (lane 0 stays 0 with ZERO_REG=1); done pulses one cycle after the 4th accept; busy falls with done.
- Stall mid-burst: base=0, len=3, drop in_valid for 2 cycles after the first word -> pointer holds; words land in lanes 0,1,2; done fires only after the third accept.
- Clear mid-burst: base=8, len=10, assert clear after 4 words -> all lanes 0, lane_valid 0, state IDLE, no done; in_ready=0 during clear.
- Priority and ignore rules:
  - burst_start with in_valid in IDLE -> in_ready=0 that cycle, no single write.
  - burst_start in BURST -> ignored.
  - burst_len=0 -> remains IDLE.
- Async reset mid-burst: drop reset_n between edges -> outputs return to reset values without waiting for clk; after release, a single write to lane 31 works normally.

Source files
------------

// File: rtl/demux32_writer_pkg.sv
// demux32_writer_pkg
// Shared constants and the FSM state encoding for the 1-to-32 write demux
// and the register-file logic that reuses its decoder.
//   LANES  : number of lanes in the bank
//   ADDR_W : lane address width
//   LEN_W  : burst length width (holds 1..32)
//   state_e: IDLE / BURST controller states
package demux32_writer_pkg;

    localparam int LANES  = 32;
    localparam int ADDR_W = 5;
    localparam int LEN_W  = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/demux32_writer_decoder5to32.sv
// decoder5to32
// Combinational 5-bit address to 32-bit one-hot decoder with enable.
//   addr   : lane address
//   en     : when low the output is all zero
//   onehot : bit addr set when en is high
module decoder5to32
    import demux32_writer_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [LANES-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/demux32_writer.sv
// demux32_writer
// 1-to-32 demultiplexer steering accepted words into 32 registered lanes,
// with single addressed writes and auto-incrementing wrapping bursts.
//   clk, reset_n    : clock, asynchronous active-low reset
//   clear           : synchronous clear of lanes/lane_valid, aborts bursts
//   in_valid/ready  : word handshake; a word moves when both are high at
//                     the rising edge. in_ready depends only on clear,
//                     burst_start and the FSM state, never on in_valid.
//   in_addr/in_data : target lane (single writes only) and data word
//   burst_start/base/len : burst request, sampled only in IDLE
//   busy, done      : in BURST / one-cycle pulse after the last burst word
//   we_onehot       : lane written on the previous edge (registered)
//   lanes           : flattened lanes, lane k at [k*WIDTH +: WIDTH]
//   lane_valid      : lanes written since reset or clear
//   dbg_state       : current controller state
module demux32_writer
    import demux32_writer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   burst_start,
    input  logic [ADDR_W-1:0]      burst_base,
    input  logic [LEN_W-1:0]       burst_len,
    output logic                   busy,
    output logic                   done,
    output logic [LANES-1:0]       we_onehot,
    output logic [LANES*WIDTH-1:0] lanes,
    output logic [LANES-1:0]       lane_valid,
    output state_e                 dbg_state
);

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              ptr_q, ptr_d;
    logic [LEN_W-1:0]               rem_q, rem_d;
    logic                           done_d;
    logic                           accept;
    logic [ADDR_W-1:0]              wr_addr;
    logic                           wr_en;
    logic [LANES-1:0]               dec;
    logic [LANES-1:0][WIDTH-1:0]    lanes_q;

    // burst_start steals the IDLE cycle so a single write never races the
    // burst setup.
    assign in_ready = ~clear & ((state_q == ST_BURST) | ~burst_start);
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == ST_BURST);
    assign dbg_state = state_q;

    assign wr_addr = (state_q == ST_BURST) ? ptr_q : in_addr;
    // Writes to lane 0 still complete the handshake but are dropped here.
    assign wr_en   = accept & ~(ZERO_REG && (wr_addr == '0));

    decoder5to32 u_dec (
        .addr   (wr_addr),
        .en     (wr_en),
        .onehot (dec)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (burst_start && (burst_len != '0)) begin
                        state_d = ST_BURST;
                        ptr_d   = burst_base;
                        rem_d   = burst_len;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        ptr_d = ptr_q + 1'b1;   // wraps 31 -> 0 naturally
                        rem_d = rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lanes_q    <= '0;
            lane_valid <= '0;
            we_onehot  <= '0;
        end else if (clear) begin
            lanes_q    <= '0;
            lane_valid <= '0;
            we_onehot  <= '0;
        end else begin
            we_onehot  <= dec;
            lane_valid <= lane_valid | dec;
            for (int k = 0; k < LANES; k++) begin
                if (dec[k]) begin
                    lanes_q[k] <= in_data;
                end
            end
        end
    end

    assign lanes = lanes_q;

endmodule
